// File: rtl/io_char_buffer.sv
// Serial-to-character assembler feeding a DEPTH-entry FIFO, drained to one of
// N_CHAN devices through a ready/strobe handshake. Single clock, synchronous reset.
module io_char_buffer #(
  parameter int                 CHAR_W      = 4,
  parameter int                 DEPTH       = 8,
  parameter int                 N_CHAN      = 4,
  parameter logic [CHAR_W-1:0]  STOP_CODE   = 4'b0100,
  parameter bit                 PAD_PARTIAL = 1'b1
) (
  input  logic                         CLOCK,
  input  logic                         rst,
  input  logic                         CLR,
  input  logic                         ENABLE,
  input  logic                         T0,
  input  logic                         BIT_IN,
  input  logic [$clog2(N_CHAN)-1:0]    CHAN_SEL,
  input  logic [N_CHAN-1:0]            DEV_READY,
  output logic [N_CHAN-1:0]            DEV_STROBE,
  output logic [CHAR_W-1:0]            DEV_DATA,
  output logic                         FULL,
  output logic                         EMPTY,
  output logic [$clog2(DEPTH+1)-1:0]   COUNT,
  output logic                         STOPPED,
  output logic                         OVERRUN
);

  localparam int CH_W  = $clog2(N_CHAN);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int BIT_W = (CHAR_W > 2) ? $clog2(CHAR_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STROBE,
    S_BUSY,
    S_REARM
  } state_t;

  // Assembler state
  logic [BIT_W-1:0]  bit_cnt;
  logic [CHAR_W-1:0] shreg;

  // FIFO state
  logic [CHAR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_nxt;

  // Output FSM state
  state_t            state_q;
  state_t            state_d;
  logic [CH_W-1:0]   ch_q;

  // Datapath decisions for this cycle
  logic              take_bit;
  logic              truncate;
  logic              complete;
  logic              cand_valid;
  logic [CHAR_W-1:0] padded;
  logic [CHAR_W-1:0] cand;
  logic              is_stop;
  logic              push;
  logic              push_ok;
  logic              drop;
  logic              launch;
  logic              sel_ok;
  logic              ready_sel;
  logic              ready_ch;

  // NOTE: every signal written in an always_comb gets a default at the top so
  // no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    take_bit   = ENABLE && !STOPPED;
    truncate   = take_bit && T0 && (bit_cnt != '0);
    complete   = take_bit && !truncate && (bit_cnt == BIT_W'(CHAR_W - 1));
    cand_valid = complete || (truncate && PAD_PARTIAL);
    // Collected bits sit in the low bit_cnt positions; shift them to the top.
    padded     = shreg << (CHAR_W - int'(bit_cnt));
    cand       = truncate ? padded : {shreg[CHAR_W-2:0], BIT_IN};
    is_stop    = cand_valid && (cand == STOP_CODE);
    push       = cand_valid && !is_stop;
    push_ok    = push && (!FULL || launch);
    drop       = push && !push_ok;
  end

  always_comb begin
    count_nxt = COUNT;
    if (push_ok && !launch) begin
      count_nxt = COUNT + 1'b1;
    end else if (!push_ok && launch) begin
      count_nxt = COUNT - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge CLOCK) begin
    if (rst || CLR) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      COUNT   <= '0;
      EMPTY   <= 1'b1;
      FULL    <= 1'b0;
      bit_cnt <= '0;
      shreg   <= '0;
      STOPPED <= 1'b0;
      OVERRUN <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (launch)  rd_ptr <= rd_ptr + 1'b1;
      COUNT <= count_nxt;
      EMPTY <= (count_nxt == '0);
      FULL  <= (count_nxt == CNT_W'(DEPTH));
      if (drop)    OVERRUN <= 1'b1;
      if (is_stop) STOPPED <= 1'b1;
      if (take_bit) begin
        if (truncate) begin
          // The T0 bit opens the next character.
          shreg   <= CHAR_W'(BIT_IN);
          bit_cnt <= BIT_W'(1);
        end else if (complete) begin
          shreg   <= '0;
          bit_cnt <= '0;
        end else begin
          shreg   <= {shreg[CHAR_W-2:0], BIT_IN};
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  // NOTE: the storage array carries no reset; occupancy is defined entirely by
  // the pointers and COUNT, so stale entries are never observed.
  always_ff @(posedge CLOCK) begin
    if (push_ok) mem[wr_ptr] <= cand;
  end

  always_comb begin
    sel_ok    = 1'b0;
    ready_sel = 1'b0;
    ready_ch  = 1'b0;
    for (int i = 0; i < N_CHAN; i++) begin
      if (CHAN_SEL == CH_W'(i)) begin
        sel_ok    = 1'b1;
        ready_sel = DEV_READY[i];
      end
      if (ch_q == CH_W'(i)) ready_ch = DEV_READY[i];
    end
  end

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!EMPTY && sel_ok && ready_sel) begin
          launch  = 1'b1;
          state_d = S_STROBE;
        end
      end
      S_STROBE: state_d = S_BUSY;
      S_BUSY:   if (!ready_ch) state_d = S_REARM;
      S_REARM:  if (ready_ch)  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    DEV_STROBE = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      if (state_q == S_STROBE && ch_q == CH_W'(i)) DEV_STROBE[i] = 1'b1;
    end
  end

  // CLR deliberately does not touch the handshake; only rst abandons it.
  always_ff @(posedge CLOCK) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ch_q     <= '0;
      DEV_DATA <= '0;
    end else begin
      state_q <= state_d;
      if (launch) begin
        ch_q     <= CHAN_SEL;
        DEV_DATA <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_io_char_buffer.sv
// Directed bench for io_char_buffer: a bit-level assembler model fills a
// scoreboard queue; a strobe monitor pops and compares each delivered character.
module tb_io_char_buffer;

  localparam int         DEPTH = 8;
  localparam logic [3:0] STOP  = 4'b0100;

  logic       CLOCK = 1'b0;
  logic       rst;
  logic       CLR;
  logic       ENABLE;
  logic       T0;
  logic       BIT_IN;
  logic [1:0] CHAN_SEL;
  logic [3:0] DEV_READY;
  logic [3:0] DEV_STROBE;
  logic [3:0] DEV_DATA;
  logic       FULL;
  logic       EMPTY;
  logic [3:0] COUNT;
  logic       STOPPED;
  logic       OVERRUN;

  logic [3:0] np_strobe;
  logic [3:0] np_data;
  logic       np_full;
  logic       np_empty;
  logic [3:0] np_count;
  logic       np_stopped;
  logic       np_overrun;

  logic [3:0] ready_man;
  logic [3:0] busy_mask = '0;
  assign DEV_READY = ready_man & ~busy_mask;

  int         n_checks  = 0;
  int         n_errors  = 0;
  int         n_strobes = 0;
  int         peak      = 0;
  int         exp_ch    = 2;
  int         busy_cnt  = 0;
  bit         dev_auto  = 1'b0;
  bit         mon_en    = 1'b0;

  logic [3:0] sb [$];
  logic [3:0] m_val;
  int         m_b;
  bit         m_stopped;
  bit         m_overrun;

  io_char_buffer #(.PAD_PARTIAL(1'b1)) u_dut (
    .CLOCK(CLOCK), .rst(rst), .CLR(CLR), .ENABLE(ENABLE), .T0(T0), .BIT_IN(BIT_IN),
    .CHAN_SEL(CHAN_SEL), .DEV_READY(DEV_READY), .DEV_STROBE(DEV_STROBE),
    .DEV_DATA(DEV_DATA), .FULL(FULL), .EMPTY(EMPTY), .COUNT(COUNT),
    .STOPPED(STOPPED), .OVERRUN(OVERRUN)
  );

  io_char_buffer #(.PAD_PARTIAL(1'b0)) u_dut_np (
    .CLOCK(CLOCK), .rst(rst), .CLR(CLR), .ENABLE(ENABLE), .T0(T0), .BIT_IN(BIT_IN),
    .CHAN_SEL(CHAN_SEL), .DEV_READY(DEV_READY), .DEV_STROBE(np_strobe),
    .DEV_DATA(np_data), .FULL(np_full), .EMPTY(np_empty), .COUNT(np_count),
    .STOPPED(np_stopped), .OVERRUN(np_overrun)
  );

  always #5 CLOCK = ~CLOCK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected-character model: MSB first, T0 truncation with zero padding.
  function automatic void m_emit(input logic [3:0] c);
    if (c == STOP) m_stopped = 1'b1;
    else if (sb.size() < DEPTH) sb.push_back(c);
    else m_overrun = 1'b1;
  endfunction

  function automatic void model_bit(input logic b, input logic t0);
    if (m_stopped) return;
    if (t0 && m_b != 0) begin
      m_emit(4'(m_val << (4 - m_b)));
      m_val = {3'b000, b};
      m_b   = 1;
    end else begin
      m_val = {m_val[2:0], b};
      m_b++;
      if (m_b == 4) begin
        m_emit(m_val);
        m_val = '0;
        m_b   = 0;
      end
    end
  endfunction

  function automatic void model_clear(input bit flush);
    m_val     = '0;
    m_b       = 0;
    m_stopped = 1'b0;
    m_overrun = 1'b0;
    if (flush) sb.delete();
  endfunction

  task automatic send_bit(input logic b, input logic t0);
    ENABLE = 1'b1;
    T0     = t0;
    BIT_IN = b;
    model_bit(b, t0);
    @(negedge CLOCK);
    ENABLE = 1'b0;
    T0     = 1'b0;
  endtask

  task automatic send_char(input logic [3:0] c);
    for (int i = 3; i >= 0; i--) send_bit(c[i], 1'b0);
  endtask

  task automatic pulse_clr();
    CLR = 1'b1;
    @(negedge CLOCK);
    CLR = 1'b0;
    model_clear(1'b0);
  endtask

  task automatic drain(input string tag);
    int cyc = 0;
    while ((sb.size() != 0 || EMPTY !== 1'b1 || busy_cnt != 0) && cyc < 300) begin
      @(negedge CLOCK);
      cyc++;
    end
    check({tag, "_drain_in_time"}, cyc < 300, 1);
    repeat (4) @(negedge CLOCK);
  endtask

  // Device model: drops ready for two cycles after each strobe it sees.
  always @(negedge CLOCK) begin
    if (rst === 1'b1) begin
      busy_mask = '0;
      busy_cnt  = 0;
    end else if (busy_cnt != 0) begin
      busy_cnt--;
      if (busy_cnt == 0) busy_mask = '0;
    end else if (dev_auto && DEV_STROBE[exp_ch] === 1'b1) begin
      busy_mask[exp_ch] = 1'b1;
      busy_cnt = 2;
    end
  end

  // Strobe monitor: each delivered character must be the scoreboard head.
  always @(negedge CLOCK) begin
    if (mon_en) begin
      if (int'(COUNT) > peak) peak = int'(COUNT);
      if (DEV_STROBE !== 4'b0000) begin
        n_strobes++;
        check("strobe_onehot", DEV_STROBE, 32'(1) << exp_ch);
        check("strobe_expected", sb.size() != 0, 1);
        if (sb.size() != 0) check("strobe_data", DEV_DATA, sb.pop_front());
      end
    end
  end

  initial begin
    int s0;
    logic [7:0] t2_bits;

    // 1: reset with undriven inputs
    rst = 1'b1; CLR = 'x; ENABLE = 'x; T0 = 'x; BIT_IN = 'x; CHAN_SEL = 'x; ready_man = 'x;
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK);
    check("rst_strobe",  DEV_STROBE, 0);
    check("rst_data",    DEV_DATA,   0);
    check("rst_full",    FULL,       0);
    check("rst_empty",   EMPTY,      1);
    check("rst_count",   COUNT,      0);
    check("rst_stopped", STOPPED,    0);
    check("rst_overrun", OVERRUN,    0);
    rst = 1'b0; CLR = 1'b0; ENABLE = 1'b0; T0 = 1'b0; BIT_IN = 1'b0;
    CHAN_SEL = 2'd2; exp_ch = 2; ready_man = 4'hF; dev_auto = 1'b1;
    model_clear(1'b1);
    mon_en = 1'b1;
    @(negedge CLOCK);

    // 2: two characters to channel 2 with handshaking device
    s0 = n_strobes; peak = 0; t2_bits = 8'b1011_0110;
    for (int i = 7; i >= 0; i--) send_bit(t2_bits[i], i == 7);
    drain("t2");
    check("t2_strobes", n_strobes - s0, 2);
    check("t2_peak",    peak >= 1 && peak <= 2, 1);
    check("t2_count",   COUNT, 0);
    check("t2_empty",   EMPTY, 1);

    // 3: stop code halts assembly until CLR
    send_char(4'b0100);
    check("t3_stopped", STOPPED, 1);
    check("t3_count",   COUNT,   0);
    send_char(4'hF);
    check("t3_ignored", COUNT,   0);
    check("t3_held",    STOPPED, 1);
    pulse_clr();
    check("t3_clr_stopped", STOPPED, 0);
    send_char(4'hF);
    check("t3_count_after", COUNT, 1);
    drain("t3");
    check("t3_data", DEV_DATA, 4'hF);

    // 4: fill with device not ready, overflow by one
    ready_man = 4'h0; s0 = n_strobes;
    for (int k = 0; k < 8; k++) send_char(4'h3);
    check("t4_full8",    FULL,    1);
    check("t4_count8",   COUNT,   8);
    check("t4_no_ovr8",  OVERRUN, 0);
    send_char(4'h3);
    check("t4_full9",    FULL,    1);
    check("t4_count9",   COUNT,   8);
    check("t4_ovr9",     OVERRUN, m_overrun);
    ready_man = 4'hF;
    drain("t4");
    check("t4_strobes",  n_strobes - s0, 8);
    check("t4_empty",    EMPTY,   1);
    check("t4_ovr_held", OVERRUN, 1);
    pulse_clr();
    check("t4_ovr_clr",  OVERRUN, 0);

    // 5: partial character at a word boundary, padded vs dropped
    rst = 1'b1;
    repeat (2) @(negedge CLOCK);
    rst = 1'b0; model_clear(1'b1);
    ready_man = 4'h0; s0 = n_strobes;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check("t5_pad_count",   COUNT,    2);
    check("t5_nopad_count", np_count, 1);
    ready_man = 4'hF;
    drain("t5");
    check("t5_strobes",     n_strobes - s0, 2);
    check("t5_nopad_data",  np_data,  4'h7);
    check("t5_nopad_empty", np_empty, 1);
    check("t5_nopad_flags", {np_full, np_stopped, np_overrun}, 3'b000);

    // 6: reset while the handshake is stuck in BUSY
    dev_auto = 1'b0; CHAN_SEL = 2'd1; exp_ch = 1; ready_man = 4'b0010; s0 = n_strobes;
    send_char(4'h5);
    send_char(4'h9);
    repeat (2) @(negedge CLOCK);
    check("t6_strobes_busy", n_strobes - s0, 1);
    check("t6_count_busy",   COUNT, 1);
    rst = 1'b1;
    @(negedge CLOCK);
    rst = 1'b0; model_clear(1'b1);
    check("t6_rst_count",  COUNT,      0);
    check("t6_rst_data",   DEV_DATA,   0);
    check("t6_rst_empty",  EMPTY,      1);
    check("t6_rst_strobe", DEV_STROBE, 0);
    repeat (6) @(negedge CLOCK);
    check("t6_no_strobe",  n_strobes - s0, 1);
    send_char(4'hA);
    drain("t6");
    check("t6_relaunch",   n_strobes - s0, 2);
    check("t6_np_strobe",  np_strobe, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
